// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 state initialiser / key scheduler.
// Holds no logic, so it adds no latency and has no flow control.
package arc4_pkg;

    localparam int KB_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        KS_RDI = 3'd2,
        KS_RDJ = 3'd3,
        KS_WRI = 3'd4,
        KS_WRJ = 3'd5
    } state_t;

    // Index width for n entries; never narrower than one bit.
    function automatic int arc4_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arc4_keybyte_mux.sv
// Picks key byte kidx from the latched key, byte 0 in the top bits.
// Purely combinational: zero latency, no flow control.
module arc4_keybyte_mux
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int KIW       = 2
) (
    input  logic [KB_W*KEY_BYTES-1:0] key,
    input  logic [KIW-1:0]            kidx,
    output logic [KB_W-1:0]           kbyte
);

    always_comb begin
        kbyte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (KIW'(b) == kidx) kbyte = key[KB_W*(KEY_BYTES-1-b) +: KB_W];
        end
    end

endmodule

// File: rtl/arc4_ksa.sv
// ARC4 S-array fill (s[i]=i) then optional KSA swap loop over a 1-cycle-latency RAM.
// Busy N cycles (MODE=0) or 5N cycles (MODE=1); en is only honoured while rdy=1.
module arc4_ksa
    import arc4_pkg::*;
#(
    parameter int N         = 256,
    parameter int DW        = 8,
    parameter int KEY_BYTES = 3,
    parameter int MODE      = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    output logic                        rdy,
    input  logic [8*KEY_BYTES-1:0]      key,
    output logic [arc4_aw(N)-1:0]       addr,
    input  logic [DW-1:0]               rddata,
    output logic [DW-1:0]               wrdata,
    output logic                        wren
);

    localparam int AW  = arc4_aw(N);
    localparam int KIW = arc4_aw(KEY_BYTES);
    localparam logic [AW-1:0]  I_LAST = AW'(N - 1);
    localparam logic [KIW-1:0] K_LAST = KIW'(KEY_BYTES - 1);

    state_t                    state_q, state_d;
    logic [AW-1:0]             i_q, i_d;
    logic [AW-1:0]             j_q, j_d;
    logic [KIW-1:0]            kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0]    key_q, key_d;
    logic [DW-1:0]             si_q, si_d;
    logic [DW-1:0]             sj;
    logic [KB_W-1:0]           kbyte;
    logic [AW-1:0]             j_new;

    arc4_keybyte_mux #(
        .KEY_BYTES (KEY_BYTES),
        .KIW       (KIW)
    ) u_keybyte_mux (
        .key   (key_q),
        .kidx  (kidx_q),
        .kbyte (kbyte)
    );

    // s[j] arrives in KS_WRI and is written back in that same cycle, so it is
    // forwarded straight from the RAM rather than held a cycle.
    assign sj    = rddata;
    assign j_new = j_q + rddata[AW-1:0] + kbyte[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
            si_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
            si_q    <= si_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        key_d   = key_q;
        si_d    = si_q;
        rdy     = 1'b0;
        addr    = '0;
        wrdata  = '0;
        wren    = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                addr   = i_q;
                wrdata = DW'(i_q);
                wren   = 1'b1;
                i_d    = i_q + 1'b1;
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    state_d = (MODE == 0) ? IDLE : KS_RDI;
                end
            end
            KS_RDI: begin
                addr    = i_q;
                state_d = KS_RDJ;
            end
            KS_RDJ: begin
                si_d    = rddata;
                j_d     = j_new;
                addr    = j_new;
                state_d = KS_WRI;
            end
            KS_WRI: begin
                addr    = i_q;
                wrdata  = sj;
                wren    = 1'b1;
                state_d = KS_WRJ;
            end
            KS_WRJ: begin
                // When i==j this rewrites the same cell with si: the swap is a no-op.
                addr    = j_q;
                wrdata  = si_q;
                wren    = 1'b1;
                i_d     = i_q + 1'b1;
                kidx_d  = (kidx_q == K_LAST) ? '0 : kidx_q + 1'b1;
                state_d = (i_q == I_LAST) ? IDLE : KS_RDI;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
